// File: rtl/mem_if_pkg.sv
// Shared definitions for the sram-like memory interface blocks: arbiter
// state encoding, grant encoding, transfer size codes and counter sizing.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Width of a counter that must hold values 0..max_run inclusive.
  function automatic int run_cnt_w(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/sramlike_grant.sv
// Grant decision for the sram-like arbiter: data master has priority, but
// after MAX_DATA_RUN consecutive data grants taken while instruction fetch
// was waiting, the next arbitration goes to instruction fetch.
module sramlike_grant
  import mem_if_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic inst_req,
  input  logic data_req,
  output logic gnt
);

  localparam int CNT_W = run_cnt_w(MAX_DATA_RUN);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_cnt_nxt;
  logic             pick_data;

  // Increment that sticks at the starvation limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + CNT_W'(1);
  endfunction

  // Priority decision and next streak count for the current request pair.
  always_comb begin
    pick_data   = data_req && !(inst_req && (run_cnt == RUN_MAX));
    run_cnt_nxt = '0;
    if (pick_data && inst_req) begin
      run_cnt_nxt = sat_inc(run_cnt);
    end
  end

  // Latch the winner and the streak count once per arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= GNT_INST;
      run_cnt <= '0;
    end else if (arb_en) begin
      gnt     <= pick_data ? GNT_DATA : GNT_INST;
      run_cnt <= run_cnt_nxt;
    end
  end

endmodule

// File: rtl/sramlike_arbiter.sv
// Shares one sram-like slave port between the core's instruction and data
// masters. One transaction in flight at a time; handshakes are steered back
// only to the granted master.
module sramlike_arbiter
  import mem_if_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok
);

  state_e state;
  logic   gnt;
  logic   gnt_req;
  logic   arb_en;

  // Arbitrate only while idle and someone is asking.
  assign arb_en  = (state == IDLE) && (inst_req || data_req);
  assign gnt_req = (gnt == GNT_DATA) ? data_req : inst_req;

  sramlike_grant #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .inst_req (inst_req),
    .data_req (data_req),
    .gnt      (gnt)
  );

  // Request mux toward the slave and handshake steering back to the masters.
  // Slave-side fields are zeroed outside the address phase so the losing
  // master's request never leaks onto mem_*.
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = SIZE_B;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    if (state == ADDR) begin
      mem_req = gnt_req;
      if (gnt == GNT_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
      inst_addr_ok = (gnt == GNT_INST) && gnt_req && mem_addr_ok;
      data_addr_ok = (gnt == GNT_DATA) && gnt_req && mem_addr_ok;
    end else if (state == DATA) begin
      inst_data_ok = (gnt == GNT_INST) && mem_data_ok;
      data_data_ok = (gnt == GNT_DATA) && mem_data_ok;
    end
  end

  // Transaction sequencing: arbitrate, issue address, wait for data, bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arb_en) state <= ADDR;
        end
        ADDR: begin
          if (!gnt_req)        state <= IDLE;
          else if (mem_addr_ok) state <= DATA;
        end
        DATA: begin
          if (mem_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
